lead_one_window_reg: RTL and testbench

//  Parametrised successor of the fixed 16-bit window register in the approximate-arithmetic datapath.
//  It captures an operand and, with SIGNED=1, takes its two's-complement magnitude.
//  It then finds the leading one by sequential left shifts.

---
 rtl/lead_one_window_reg.sv | 133 +++++++++++++
 tb/tb_lead_one_window_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lead_one_window_reg.sv
// Leading-one window register.
// Captures an operand (optionally taking its two's-complement magnitude),
// scans for the leading one by shifting left once per cycle, then reports
// the leading-one position and a WIN-bit window that starts at that one.
//
// Handshake: start is accepted on a rising edge when the block is not busy
// (state IDLE or DONE). done is a one-cycle pulse. There is no backpressure.
// The registered results (position, Y, zero, sign) stay valid from the done
// cycle until the next done or reset.
module lead_one_window_reg #(
  parameter int SIZE        = 16,
  parameter int WIN         = 8,
  parameter int ADDRESSSIZE = 4,
  parameter bit SIGNED      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SIZE-1:0]        in_data,
  output logic                   busy,
  output logic                   done,
  output logic                   zero,
  output logic                   sign,
  output logic [ADDRESSSIZE-1:0] position,
  output logic [WIN-1:0]         Y,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SIZE-1:0]        shreg_q, shreg_d;
  logic [ADDRESSSIZE-1:0] cnt_q, cnt_d;
  logic                   sign_cap_q, sign_cap_d;
  logic [ADDRESSSIZE-1:0] pos_q, pos_d;
  logic [WIN-1:0]         y_q, y_d;
  logic                   zero_q, zero_d;
  logic                   sign_q, sign_d;

  logic [SIZE-1:0]        mag;
  logic                   sign_in;

  // Operand magnitude; the most-negative value wraps to itself (1 followed by zeros).
  always_comb begin
    sign_in = SIGNED ? in_data[SIZE-1] : 1'b0;
    mag     = in_data;
    if (sign_in) begin
      mag = (~in_data) + SIZE'(1);
    end
  end

  // Next-state and datapath updates for the scan FSM.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    sign_cap_d = sign_cap_q;
    pos_d      = pos_q;
    y_d        = y_q;
    zero_d     = zero_q;
    sign_d     = sign_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE falls back to IDLE unless a new request arrives (back-to-back).
        state_d = ST_IDLE;
        if (start) begin
          shreg_d    = mag;
          cnt_d      = ADDRESSSIZE'(SIZE - 1);
          sign_cap_d = sign_in;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (shreg_q[SIZE-1]) begin
          // Leading one sits at the MSB; lower bits were zero-filled by the shifts.
          pos_d   = cnt_q;
          y_d     = shreg_q[SIZE-1 -: WIN];
          zero_d  = 1'b0;
          sign_d  = sign_cap_q;
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          pos_d   = '0;
          y_d     = '0;
          zero_d  = 1'b1;
          sign_d  = sign_cap_q;
          state_d = ST_DONE;
        end else begin
          shreg_d = {shreg_q[SIZE-2:0], 1'b0};
          cnt_d   = cnt_q - ADDRESSSIZE'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      sign_cap_q <= 1'b0;
      pos_q      <= '0;
      y_q        <= '0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      sign_cap_q <= sign_cap_d;
      pos_q      <= pos_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      sign_q     <= sign_d;
    end
  end

  assign busy      = (state_q == ST_SCAN);
  assign done      = (state_q == ST_DONE);
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign position  = pos_q;
  assign Y         = y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lead_one_window_reg.sv
// Bench for lead_one_window_reg: one unsigned and one signed instance driven
// with the same operands; expected results come from an arithmetic model and
// are checked by per-instance monitors popping from expected queues.
module tb_lead_one_window_reg;

  localparam int CLK_HALF = 5;

  typedef struct packed {
    logic [31:0] issue;
    logic [7:0]  lat;
    logic        sign;
    logic        zero;
    logic [3:0]  pos;
    logic [7:0]  y;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] in_data = '0;
  always #CLK_HALF clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       busy_u, done_u, zero_u, sign_u;
  logic [3:0] pos_u;
  logic [7:0] y_u;
  logic [1:0] st_u;
  logic       busy_s, done_s, zero_s, sign_s;
  logic [3:0] pos_s;
  logic [7:0] y_s;
  logic [1:0] st_s;

  lead_one_window_reg #(.SIZE(16), .WIN(8), .ADDRESSSIZE(4), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .busy(busy_u), .done(done_u), .zero(zero_u), .sign(sign_u),
    .position(pos_u), .Y(y_u), .dbg_state(st_u)
  );

  lead_one_window_reg #(.SIZE(16), .WIN(8), .ADDRESSSIZE(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .busy(busy_s), .done(done_s), .zero(zero_s), .sign(sign_s),
    .position(pos_s), .Y(y_s), .dbg_state(st_s)
  );

  // scoreboard
  exp_t exp_u_q[$];
  exp_t exp_s_q[$];
  int n_vec = 0;
  int n_err = 0;
  int bcnt_u = 0;
  int bcnt_s = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: magnitude by integer arithmetic, leading one as highest set bit.
  function automatic exp_t model(input logic [15:0] v, input bit sgn);
    exp_t e;
    int   m;
    int   p;
    e = '0;
    m = int'(v);
    if (sgn && m >= 32768) m = (65536 - m) % 65536;
    p = -1;
    for (int b = 0; b < 16; b++) if (((m >> b) % 2) == 1) p = b;
    e.sign = sgn && (v >= 16'h8000);
    if (p < 0) begin
      e.zero = 1'b1;
      e.lat  = 8'd17;
    end else begin
      e.pos = 4'(p);
      e.lat = 8'(16 - p + 1);
      if (p >= 7) e.y = 8'((m >> (p - 7)) % 256);
      else        e.y = 8'((m << (7 - p)) % 256);
    end
    return e;
  endfunction

  task automatic check_done(input string tag, input exp_t e, input logic [3:0] pos,
                            input logic [7:0] y, input logic z, input logic s, input int bc);
    cmp({tag, "_position"}, 32'(pos), 32'(e.pos));
    cmp({tag, "_Y"}, 32'(y), 32'(e.y));
    cmp({tag, "_zero"}, 32'(z), 32'(e.zero));
    cmp({tag, "_sign"}, 32'(s), 32'(e.sign));
    cmp({tag, "_latency"}, 32'(cyc) - e.issue, 32'(e.lat));
    cmp({tag, "_busy_cycles"}, 32'(bc), 32'(e.lat) - 32'd1);
  endtask

  // monitor: unsigned instance
  always @(negedge clk) begin
    if (rst) begin
      bcnt_u = 0;
    end else begin
      cmp("u_busy_done_excl", 32'(busy_u & done_u), 32'd0);
      if (busy_u) bcnt_u++;
      if (done_u) begin
        if (exp_u_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL u_unexpected_done: got done=1, expected no pending request (cycle %0d)", cyc);
        end else begin
          check_done("u", exp_u_q.pop_front(), pos_u, y_u, zero_u, sign_u, bcnt_u);
        end
        bcnt_u = 0;
      end
    end
  end

  // monitor: signed instance
  always @(negedge clk) begin
    if (rst) begin
      bcnt_s = 0;
    end else begin
      cmp("s_busy_done_excl", 32'(busy_s & done_s), 32'd0);
      if (busy_s) bcnt_s++;
      if (done_s) begin
        if (exp_s_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL s_unexpected_done: got done=1, expected no pending request (cycle %0d)", cyc);
        end else begin
          check_done("s", exp_s_q.pop_front(), pos_s, y_s, zero_s, sign_s, bcnt_s);
        end
        bcnt_s = 0;
      end
    end
  end

  // driver tasks (called right after a negedge)
  task automatic issue(input logic [15:0] v);
    exp_t e;
    int   guard;
    guard = 0;
    while ((busy_u || busy_s) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_vec++; n_err++;
      $display("FAIL issue_wait: got busy after %0d cycles, expected idle", guard);
    end
    e = model(v, 1'b0); e.issue = 32'(cyc); exp_u_q.push_back(e);
    e = model(v, 1'b1); e.issue = 32'(cyc); exp_s_q.push_back(e);
    start   = 1'b1;
    in_data = v;
    @(negedge clk);
    start   = 1'b0;
    in_data = 16'($urandom);
  endtask

  // Pulse start while both instances are scanning; must be ignored.
  task automatic pulse_busy_start();
    start   = 1'b1;
    in_data = 16'($urandom);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    cmp({tag, "_busy"}, 32'({busy_u, busy_s}), 32'd0);
    cmp({tag, "_done"}, 32'({done_u, done_s}), 32'd0);
    cmp({tag, "_zero_sign"}, 32'({zero_u, sign_u, zero_s, sign_s}), 32'd0);
    cmp({tag, "_position"}, 32'({pos_u, pos_s}), 32'd0);
    cmp({tag, "_Y"}, 32'({y_u, y_s}), 32'd0);
    cmp({tag, "_state"}, 32'({st_u, st_s}), 32'd0);
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  // main stimulus
  initial begin
    logic [15:0] v;
    int guard;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    issue(16'h0B40);
    issue(16'h0005);
    issue(16'h0000);
    issue(16'hFFF4);
    issue(16'h8000);
    issue(16'h0001);   // lands in the DONE cycle of the previous request
    issue(16'h0B40);
    pulse_busy_start();

    // reset during the third scan cycle
    issue(16'h0005);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midscan_reset");
    exp_u_q.delete();
    exp_s_q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0B40);

    // randomized operands spread over all magnitudes
    for (int i = 0; i < 250; i++) begin
      v = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      if ($urandom_range(0, 9) == 0) v = 16'h8000;
      issue(v);
      if ($urandom_range(0, 4) == 0) pulse_busy_start();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // drain
    guard = 0;
    while ((exp_u_q.size() != 0 || exp_s_q.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    cmp("drain_pending", 32'(exp_u_q.size() + exp_s_q.size()), 32'd0);
    report();
    $finish;
  end

  // watchdog
  initial begin
    #(2 * CLK_HALF * 60000);
    n_vec++; n_err++;
    $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
    report();
    $finish;
  end

endmodule
